prio_write_regbank: RTL and testbench

- Parametrised successor to the two-writer priority register: a DEPTH-entry, WIDTH-bit register bank written by NCH independent write channels in the same clock edge.
- Same-address conflicts resolve by a fixed, parameter-selected channel priority.
- Conflicts are counted and flagged for the synthesis/simulation regression benches.
- Sits as a leaf storage element under the synthesis-on test wrappers.

---
 rtl/prio_write_regbank.sv | 76 +++++++
 tb/tb_prio_write_regbank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/prio_write_regbank.sv
// prio_write_regbank: DEPTH x WIDTH register bank with NCH same-edge writers,
// fixed channel priority on address conflicts and a saturating collision counter.
module prio_write_regbank #(
    parameter int               WIDTH     = 2,
    parameter int               DEPTH     = 4,
    parameter int               NCH       = 2,
    parameter bit               LAST_WINS = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CW        = 4,
    localparam int              AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       wr_en,
    input  logic [NCH*AW-1:0]    wr_addr,
    input  logic [NCH*WIDTH-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic [CW-1:0]        coll_cnt,
    output logic                 coll_flag,
    input  logic                 coll_clr
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] nxt [DEPTH];
    logic [NCH-1:0]   vld;
    logic             coll;

    // Channels are visited lowest priority first so the winner writes last.
    function automatic int ch(input int k);
        return LAST_WINS ? k : NCH - 1 - k;
    endfunction

    always_comb begin
        for (int i = 0; i < NCH; i++)
            vld[i] = wr_en[i] && (int'(wr_addr[i*AW +: AW]) < DEPTH);
    end

    always_comb begin
        coll = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            nxt[e] = mem[e];
            for (int k = 0; k < NCH; k++)
                if (vld[ch(k)] && int'(wr_addr[ch(k)*AW +: AW]) == e)
                    nxt[e] = wr_data[ch(k)*WIDTH +: WIDTH];
        end
        for (int i = 0; i < NCH; i++)
            for (int j = i + 1; j < NCH; j++)
                if (vld[i] && vld[j] && wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])
                    coll = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++)
                mem[e] <= RESET_VAL;
            rd_data <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++)
                mem[e] <= nxt[e];
            rd_data <= (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt  <= '0;
            coll_flag <= 1'b0;
        end else if (coll_clr) begin
            coll_cnt  <= '0;
            coll_flag <= 1'b0;
        end else if (coll) begin
            coll_cnt  <= (coll_cnt == {CW{1'b1}}) ? coll_cnt : coll_cnt + 1'b1;
            coll_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_prio_write_regbank.sv
// tb_prio_write_regbank: checks a default bank and a 3-channel lowest-wins bank
// against a queue-based reference model plus directed vectors.
module tb_prio_write_regbank;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] a_en;
    logic [3:0] a_addr, a_data;
    logic [1:0] a_rda, a_rd;
    logic [3:0] a_cnt;
    logic       a_clr, a_flag;

    logic [2:0] b_en, b_rda, b_rd;
    logic [8:0] b_addr, b_data;
    logic [1:0] b_cnt;
    logic       b_clr, b_flag;

    int en_v[2][3], addr_v[2][3], data_v[2][3], rda_v[2], clr_v[2];
    int dep[2], nch[2], lw[2], cmax[2], rstv[2];
    int mem[2][8], erd[2], ecnt[2], eflg[2];
    int nchk = 0, nfail = 0;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            a_en[i]           = en_v[0][i] != 0;
            a_addr[i*2 +: 2]  = 2'(addr_v[0][i]);
            a_data[i*2 +: 2]  = 2'(data_v[0][i]);
        end
        for (int i = 0; i < 3; i++) begin
            b_en[i]           = en_v[1][i] != 0;
            b_addr[i*3 +: 3]  = 3'(addr_v[1][i]);
            b_data[i*3 +: 3]  = 3'(data_v[1][i]);
        end
        a_rda = 2'(rda_v[0]);
        b_rda = 3'(rda_v[1]);
        a_clr = clr_v[0] != 0;
        b_clr = clr_v[1] != 0;
    end

    prio_write_regbank dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(a_en), .wr_addr(a_addr), .wr_data(a_data),
        .rd_addr(a_rda), .rd_data(a_rd), .coll_cnt(a_cnt), .coll_flag(a_flag), .coll_clr(a_clr)
    );

    prio_write_regbank #(.WIDTH(3), .DEPTH(5), .NCH(3), .LAST_WINS(0), .RESET_VAL(3'd5), .CW(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(b_en), .wr_addr(b_addr), .wr_data(b_data),
        .rd_addr(b_rda), .rd_data(b_rd), .coll_cnt(b_cnt), .coll_flag(b_flag), .coll_clr(b_clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < 8; e++) mem[d][e] = rstv[d];
            erd[d] = 0; ecnt[d] = 0; eflg[d] = 0;
        end
    endtask

    // Per entry: gather the list of enabled in-range writers, pick first or last.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int nm[8];
            bit col;
            int q[$];
            col = 0;
            for (int e = 0; e < 8; e++) nm[e] = mem[d][e];
            erd[d] = (rda_v[d] < dep[d]) ? mem[d][rda_v[d]] : 0;
            for (int e = 0; e < dep[d]; e++) begin
                q.delete();
                for (int i = 0; i < nch[d]; i++)
                    if (en_v[d][i] != 0 && addr_v[d][i] == e) q.push_back(i);
                if (q.size() >= 2) col = 1;
                if (q.size() > 0) nm[e] = data_v[d][lw[d] != 0 ? q[q.size()-1] : q[0]];
            end
            for (int e = 0; e < 8; e++) mem[d][e] = nm[e];
            if (clr_v[d] != 0) begin
                ecnt[d] = 0; eflg[d] = 0;
            end else if (col) begin
                if (ecnt[d] < cmax[d]) ecnt[d]++;
                eflg[d] = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("A rd_data", int'(a_rd), erd[0]);
        chk("A coll_cnt", int'(a_cnt), ecnt[0]);
        chk("A coll_flag", int'(a_flag), eflg[0]);
        chk("B rd_data", int'(b_rd), erd[1]);
        chk("B coll_cnt", int'(b_cnt), ecnt[1]);
        chk("B coll_flag", int'(b_flag), eflg[1]);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                en_v[d][i] = 0; addr_v[d][i] = 0; data_v[d][i] = 0;
            end
            clr_v[d] = 0;
        end
    endtask

    task automatic set_w(input int d, input int i, input int a, input int v);
        en_v[d][i] = 1; addr_v[d][i] = a; data_v[d][i] = v;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int en, a0, a1, d0, d1, rda, clr;
        int rd, cnt, flg;
    } vec_t;
    vec_t tbl[12];

    initial begin
        dep  = '{4, 5}; nch = '{2, 3}; lw = '{1, 0};
        cmax = '{15, 3}; rstv = '{0, 5};
        tbl[0]  = '{3, 0, 0, 1, 2, 0, 0,  0, 1, 1};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0,  2, 1, 1};
        tbl[2]  = '{1, 0, 0, 1, 0, 0, 0,  2, 1, 1};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0,  1, 1, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0,  1, 1, 1};
        tbl[5]  = '{2, 0, 0, 0, 2, 0, 0,  1, 1, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0,  2, 1, 1};
        tbl[7]  = '{3, 1, 2, 3, 1, 0, 0,  2, 1, 1};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 0,  3, 1, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 2, 0,  1, 1, 1};
        tbl[10] = '{3, 3, 3, 1, 3, 3, 1,  0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 3, 0,  3, 0, 0};
        idle();
        rda_v[0] = 0; rda_v[1] = 0;
        do_reset();

        for (int k = 0; k < 12; k++) begin
            idle();
            en_v[0][0] = tbl[k].en & 1;  en_v[0][1] = (tbl[k].en >> 1) & 1;
            addr_v[0][0] = tbl[k].a0;    addr_v[0][1] = tbl[k].a1;
            data_v[0][0] = tbl[k].d0;    data_v[0][1] = tbl[k].d1;
            rda_v[0] = tbl[k].rda;       clr_v[0] = tbl[k].clr;
            tick();
            chk($sformatf("tbl[%0d] rd_data", k), int'(a_rd), tbl[k].rd);
            chk($sformatf("tbl[%0d] coll_cnt", k), int'(a_cnt), tbl[k].cnt);
            chk($sformatf("tbl[%0d] coll_flag", k), int'(a_flag), tbl[k].flg);
        end

        idle();
        set_w(1, 0, 2, 1); set_w(1, 1, 2, 2); set_w(1, 2, 2, 3);
        rda_v[1] = 2;
        tick();
        chk("B 3-way rd pre-write", int'(b_rd), 5);
        chk("B 3-way cnt", int'(b_cnt), 1);
        idle();
        tick();
        chk("B lowest wins", int'(b_rd), 1);
        set_w(1, 1, 1, 2); set_w(1, 2, 3, 3);
        tick();
        chk("B split writes cnt", int'(b_cnt), 1);
        idle();
        rda_v[1] = 1;
        tick();
        chk("B addr1", int'(b_rd), 2);
        rda_v[1] = 3;
        tick();
        chk("B addr3", int'(b_rd), 3);
        set_w(1, 0, 5, 7); set_w(1, 1, 5, 6); set_w(1, 2, 7, 1);
        rda_v[1] = 6;
        tick();
        chk("B oor write no coll", int'(b_cnt), 1);
        chk("B oor read", int'(b_rd), 0);
        for (int k = 0; k < 5; k++) begin
            idle();
            set_w(1, 0, 4, k); set_w(1, 2, 4, 7 - k);
            tick();
        end
        chk("B saturate cnt", int'(b_cnt), 3);
        chk("B saturate flag", int'(b_flag), 1);
        set_w(1, 0, 0, 1); set_w(1, 1, 0, 2);
        clr_v[1] = 1;
        tick();
        chk("B clr wins cnt", int'(b_cnt), 0);
        chk("B clr wins flag", int'(b_flag), 0);

        idle();
        set_w(0, 0, 1, 2); set_w(0, 1, 1, 1);
        do_reset();
        chk("A async rd", int'(a_rd), 0);
        chk("A async cnt", int'(a_cnt), 0);
        chk("B async flag", int'(b_flag), 0);
        for (int e = 0; e < 8; e++) begin
            idle();
            rda_v[0] = e % 4; rda_v[1] = e;
            tick();
            chk($sformatf("A post-reset addr%0d", e % 4), int'(a_rd), 0);
            chk($sformatf("B post-reset addr%0d", e), int'(b_rd), e < 5 ? 5 : 0);
        end

        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < nch[d]; i++) begin
                    en_v[d][i]   = int'($urandom_range(0, 1));
                    addr_v[d][i] = int'($urandom_range(0, d == 0 ? 3 : 7));
                    data_v[d][i] = int'($urandom_range(0, d == 0 ? 3 : 7));
                end
                rda_v[d] = int'($urandom_range(0, d == 0 ? 3 : 7));
                clr_v[d] = ($urandom_range(0, 15) == 0) ? 1 : 0;
            end
            if ($urandom_range(0, 149) == 0) do_reset();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
